// File: rtl/rs_age_scheduler_pkg.sv
// Shared types and sizing for the reservation-station age scheduler.
package sched_pkg;

  localparam int RS_DEPTH = 16;
  localparam int ALLOC_W  = 4;
  localparam int RS_IDX_W = $clog2(RS_DEPTH);

  typedef logic [RS_IDX_W-1:0]     rs_idx_t;
  typedef logic [RS_IDX_W:0]       rs_cnt_t;
  typedef logic [RS_DEPTH-1:0]     age_row_t;
  // age_mat_t[i][j] = 1 means entry i is older than entry j
  typedef age_row_t [RS_DEPTH-1:0] age_mat_t;

  // Encode a one-hot (or all-zero) vector into an index; zero maps to 0.
  function automatic rs_idx_t onehot_to_idx(age_row_t oh);
    rs_idx_t idx;
    idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (oh[i]) idx |= rs_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rs_age_scheduler_age_oldest_pick.sv
// Combinational oldest-entry pick over an eligibility vector using the age matrix.
module age_oldest_pick
  import sched_pkg::*;
(
  input  age_row_t elig_i,
  input  age_mat_t age_i,
  output age_row_t oldest_o,
  output rs_idx_t  idx_o,
  output logic     found_o
);

  age_row_t cand;

  // An eligible entry is a candidate when no other eligible entry is older than it.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    cand = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      cand[i] = elig_i[i];
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (elig_i[j] && age_i[j][i]) cand[i] = 1'b0;
      end
    end
  end

  // Isolate the lowest candidate bit so the result stays one-hot even on a corrupted matrix.
  assign oldest_o = cand & (~cand + age_row_t'(1));
  assign idx_o    = onehot_to_idx(oldest_o);
  assign found_o  = |cand;

endmodule

// File: rtl/rs_age_scheduler.sv
// Oldest-first dual-issue scheduler: valid vector, age matrix and occupancy counter,
// with zero-latency grant steering to ALU0/ALU1.
module rs_age_scheduler
  import sched_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [ALLOC_W-1:0]        alloc_valid,
  input  rs_idx_t [ALLOC_W-1:0]     alloc_idx,
  input  logic [RS_DEPTH-1:0]       ready_mask,
  input  logic                      alu0_ready,
  input  logic                      alu1_ready,
  output logic                      alu0_valid,
  output rs_idx_t                   alu0_rs_idx,
  output logic                      alu1_valid,
  output rs_idx_t                   alu1_rs_idx,
  output logic [RS_DEPTH-1:0]       issue_grant_mask,
  output logic [RS_DEPTH-1:0]       entry_valid,
  output logic [RS_IDX_W:0]         occupancy
);

  age_row_t valid_q, valid_d;
  age_mat_t age_q, age_d;
  rs_cnt_t  occ_q, occ_d;

  age_row_t elig, elig_second;
  age_row_t first_oh, second_oh;
  rs_idx_t  first_idx, second_idx;
  logic     first_found, second_found;

  assign elig        = valid_q & ready_mask;
  assign elig_second = elig & ~first_oh;

  age_oldest_pick u_pick_first (
    .elig_i   (elig),
    .age_i    (age_q),
    .oldest_o (first_oh),
    .idx_o    (first_idx),
    .found_o  (first_found)
  );

  age_oldest_pick u_pick_second (
    .elig_i   (elig_second),
    .age_i    (age_q),
    .oldest_o (second_oh),
    .idx_o    (second_idx),
    .found_o  (second_found)
  );

  // Steer the oldest ready entry to the first available ALU, the runner-up to ALU1 when both accept.
  always_comb begin
    alu0_valid       = 1'b0;
    alu0_rs_idx      = '0;
    alu1_valid       = 1'b0;
    alu1_rs_idx      = '0;
    issue_grant_mask = '0;
    if (alu0_ready) begin
      alu0_valid       = first_found;
      alu0_rs_idx      = first_idx;
      issue_grant_mask = first_oh;
      if (alu1_ready) begin
        alu1_valid       = second_found;
        alu1_rs_idx      = second_idx;
        issue_grant_mask = first_oh | second_oh;
      end
    end else if (alu1_ready) begin
      alu1_valid       = first_found;
      alu1_rs_idx      = first_idx;
      issue_grant_mask = first_oh;
    end
  end

  // Next state: drop granted entries, insert allocations younger than all survivors,
  // ordered among themselves by lane number.
  always_comb begin
    age_row_t survivors, earlier, later, alloc_mask;
    survivors  = valid_q & ~issue_grant_mask;
    alloc_mask = '0;
    age_d      = age_q;
    for (int k = 0; k < ALLOC_W; k++) begin
      earlier = '0;
      later   = '0;
      for (int m = 0; m < ALLOC_W; m++) begin
        if (alloc_valid[m]) begin
          if (m < k)      earlier[alloc_idx[m]] = 1'b1;
          else if (m > k) later[alloc_idx[m]]   = 1'b1;
        end
      end
      if (alloc_valid[k]) begin
        alloc_mask[alloc_idx[k]] = 1'b1;
        age_d[alloc_idx[k]]      = later;
        for (int j = 0; j < RS_DEPTH; j++) begin
          age_d[j][alloc_idx[k]] = survivors[j] | earlier[j];
        end
      end
    end
    valid_d = survivors | alloc_mask;
    occ_d   = occ_q + rs_cnt_t'($countones(alloc_valid))
                    - rs_cnt_t'($countones(issue_grant_mask));
  end

  // State registers: reset beats flush, flush drops same-cycle allocations.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst || flush) begin
      valid_q <= '0;
      age_q   <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
      occ_q   <= occ_d;
    end
  end

  assign entry_valid = valid_q;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_rs_age_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// sequence-number model of entry age.
module tb_rs_age_scheduler;
  import sched_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic [ALLOC_W-1:0]    alloc_valid;
  rs_idx_t [ALLOC_W-1:0] alloc_idx;
  logic [RS_DEPTH-1:0]   ready_mask;
  logic                  alu0_ready;
  logic                  alu1_ready;
  logic                  alu0_valid;
  rs_idx_t               alu0_rs_idx;
  logic                  alu1_valid;
  rs_idx_t               alu1_rs_idx;
  logic [RS_DEPTH-1:0]   issue_grant_mask;
  logic [RS_DEPTH-1:0]   entry_valid;
  logic [RS_IDX_W:0]     occupancy;

  rs_age_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .alloc_valid      (alloc_valid),
    .alloc_idx        (alloc_idx),
    .ready_mask       (ready_mask),
    .alu0_ready       (alu0_ready),
    .alu1_ready       (alu1_ready),
    .alu0_valid       (alu0_valid),
    .alu0_rs_idx      (alu0_rs_idx),
    .alu1_valid       (alu1_valid),
    .alu1_rs_idx      (alu1_rs_idx),
    .issue_grant_mask (issue_grant_mask),
    .entry_valid      (entry_valid),
    .occupancy        (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: an entry is valid with an allocation sequence number; smaller number = older.
  bit              mv   [RS_DEPTH];
  longint unsigned mseq [RS_DEPTH];
  longint unsigned next_seq = 0;

  // Last sampled DUT outputs, for scenario-specific checks.
  logic                obs_a0v, obs_a1v;
  rs_idx_t             obs_a0i, obs_a1i;
  logic [RS_DEPTH-1:0] obs_gm, obs_ev;
  logic [RS_IDX_W:0]   obs_occ;

  function automatic int oldest(input logic [RS_DEPTH-1:0] el);
    int best = -1;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (el[i] && (best < 0 || mseq[i] < mseq[best])) best = i;
    end
    return best;
  endfunction

  function automatic rs_idx_t [ALLOC_W-1:0] lanes(input int s0, input int s1, input int s2, input int s3);
    rs_idx_t [ALLOC_W-1:0] l;
    l[0] = rs_idx_t'(s0);
    l[1] = rs_idx_t'(s1);
    l[2] = rs_idx_t'(s2);
    l[3] = rs_idx_t'(s3);
    return l;
  endfunction

  // One clock: drive inputs, check outputs against the model mid-cycle, then advance the model.
  task automatic step(input bit r, input bit f, input logic [ALLOC_W-1:0] av,
                      input rs_idx_t [ALLOC_W-1:0] ai, input logic [RS_DEPTH-1:0] rm,
                      input bit r0, input bit r1);
    logic [RS_DEPTH-1:0] el, gm, ev;
    int fst, snd, e_a0, e_a1, cnt;
    bit viol;
    rst = r; flush = f; alloc_valid = av; alloc_idx = ai;
    ready_mask = rm; alu0_ready = r0; alu1_ready = r1;

    el = '0;
    ev = '0;
    cnt = 0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      el[i] = mv[i] & rm[i];
      ev[i] = mv[i];
      cnt += int'(mv[i]);
    end
    fst = oldest(el);
    if (fst >= 0) el[fst] = 1'b0;
    snd = oldest(el);
    e_a0 = -1;
    e_a1 = -1;
    if (r0) begin
      e_a0 = fst;
      if (r1) e_a1 = snd;
    end else if (r1) begin
      e_a1 = fst;
    end
    gm = '0;
    if (e_a0 >= 0) gm[e_a0] = 1'b1;
    if (e_a1 >= 0) gm[e_a1] = 1'b1;

    viol = 1'b0;
    for (int k = 0; k < ALLOC_W; k++) begin
      if (av[k]) begin
        if (mv[ai[k]]) viol = 1'b1;
        for (int m = k + 1; m < ALLOC_W; m++) if (av[m] && ai[m] == ai[k]) viol = 1'b1;
      end
    end

    @(negedge clk);
    obs_a0v = alu0_valid;  obs_a0i = alu0_rs_idx;
    obs_a1v = alu1_valid;  obs_a1i = alu1_rs_idx;
    obs_gm  = issue_grant_mask;
    obs_ev  = entry_valid;
    obs_occ = occupancy;
    if (!r) begin
      check("alloc_protocol", 64'(viol), 64'd0);
      check("alu0_valid", 64'(obs_a0v), 64'(e_a0 >= 0));
      check("alu0_rs_idx", 64'(obs_a0i), 64'((e_a0 >= 0) ? e_a0 : 0));
      check("alu1_valid", 64'(obs_a1v), 64'(e_a1 >= 0));
      check("alu1_rs_idx", 64'(obs_a1i), 64'((e_a1 >= 0) ? e_a1 : 0));
      check("grant_mask", 64'(obs_gm), 64'(gm));
      check("entry_valid", 64'(obs_ev), 64'(ev));
      check("occupancy", 64'(obs_occ), 64'(cnt));
    end

    @(posedge clk);
    if (r || f) begin
      for (int i = 0; i < RS_DEPTH; i++) mv[i] = 1'b0;
    end else begin
      if (e_a0 >= 0) mv[e_a0] = 1'b0;
      if (e_a1 >= 0) mv[e_a1] = 1'b0;
      for (int k = 0; k < ALLOC_W; k++) begin
        if (av[k]) begin
          mv[ai[k]]   = 1'b1;
          mseq[ai[k]] = next_seq;
          next_seq++;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input logic [RS_DEPTH-1:0] rm, input bit r0, input bit r1);
    step(1'b0, 1'b0, '0, lanes(0, 0, 0, 0), rm, r0, r1);
  endtask

  task automatic rand_cycle();
    int free_q[$];
    logic [ALLOC_W-1:0] av;
    rs_idx_t [ALLOC_W-1:0] ai;
    logic [RS_DEPTH-1:0] rm;
    int pick;
    for (int i = 0; i < RS_DEPTH; i++) if (!mv[i]) free_q.push_back(i);
    av = '0;
    ai = lanes(0, 0, 0, 0);
    for (int k = 0; k < ALLOC_W; k++) begin
      if (free_q.size() > 0 && $urandom_range(0, 99) < 35) begin
        pick     = int'($urandom_range(0, free_q.size() - 1));
        av[k]    = 1'b1;
        ai[k]    = rs_idx_t'(free_q[pick]);
        free_q.delete(pick);
      end
    end
    rm = RS_DEPTH'($urandom) & RS_DEPTH'($urandom | $urandom);
    step($urandom_range(0, 399) == 0, $urandom_range(0, 99) < 2, av, ai, rm,
         $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_valid = '0; alloc_idx = lanes(0, 0, 0, 0);
    ready_mask = '0; alu0_ready = 1'b0; alu1_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset then idle
    step(1'b1, 1'b0, '0, lanes(0, 0, 0, 0), '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, lanes(0, 0, 0, 0), '0, 1'b0, 1'b0);
    idle('0, 1'b0, 1'b0);
    check("t1_occ", 64'(obs_occ), 64'd0);
    check("t1_gm", 64'(obs_gm), 64'd0);

    // In-order dispatch, reverse readiness
    step(1'b0, 1'b0, 4'b0111, lanes(5, 2, 9, 0), '0, 1'b1, 1'b1);
    idle(16'h0204, 1'b1, 1'b1);
    check("t2_alu0", 64'(obs_a0i), 64'd2);
    check("t2_alu1", 64'(obs_a1i), 64'd9);
    check("t2_occ_pre", 64'(obs_occ), 64'd3);
    idle(16'h0000, 1'b1, 1'b1);
    check("t2_occ_post", 64'(obs_occ), 64'd1);
    idle(16'h0020, 1'b1, 1'b1);

    // Age across cycles, ALU1-only acceptance
    step(1'b0, 1'b0, 4'b0001, lanes(7, 0, 0, 0), '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 4'b0001, lanes(3, 0, 0, 0), '0, 1'b1, 1'b1);
    idle(16'h0088, 1'b0, 1'b1);
    check("t3_alu1", 64'(obs_a1i), 64'd7);
    check("t3_alu0v", 64'(obs_a0v), 64'd0);
    idle(16'h0008, 1'b1, 1'b1);
    check("t3_next", 64'(obs_a0i), 64'd3);

    // Backpressure
    step(1'b0, 1'b0, 4'b1111, lanes(1, 6, 12, 14), '0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      idle(16'hffff, 1'b0, 1'b0);
      check("t4_hold_gm", 64'(obs_gm), 64'd0);
      check("t4_hold_ev", 64'(obs_ev), 64'h5042);
    end
    idle(16'hffff, 1'b1, 1'b1);
    check("t4_rel_a0", 64'(obs_a0i), 64'd1);
    check("t4_rel_a1", 64'(obs_a1i), 64'd6);
    idle(16'hffff, 1'b1, 1'b1);
    check("t4_rel2_gm", 64'(obs_gm), 64'h5000);

    // Flush mid-stream
    step(1'b0, 1'b0, 4'b1111, lanes(0, 1, 2, 3), '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b0011, lanes(4, 5, 0, 0), '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0001, lanes(11, 0, 0, 0), '0, 1'b0, 1'b0);
    idle('0, 1'b0, 1'b0);
    check("t5_ev", 64'(obs_ev), 64'd0);
    check("t5_occ", 64'(obs_occ), 64'd0);

    // Slot reuse after grant
    step(1'b0, 1'b0, 4'b0001, lanes(8, 0, 0, 0), '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 4'b0001, lanes(4, 0, 0, 0), '0, 1'b1, 1'b1);
    idle(16'h0010, 1'b1, 1'b1);
    check("t6_grant4", 64'(obs_a0i), 64'd4);
    step(1'b0, 1'b0, 4'b0001, lanes(4, 0, 0, 0), '0, 1'b1, 1'b1);
    idle(16'h0110, 1'b1, 1'b1);
    check("t6_alu0", 64'(obs_a0i), 64'd8);
    check("t6_alu1", 64'(obs_a1i), 64'd4);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) rand_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_age_scheduler.md
Name: rs_age_scheduler

Overview:
- Oldest-first issue scheduler for the reservation station.
- Keeps a per-entry valid vector and an RS_DEPTH x RS_DEPTH age matrix, updated on allocation, grant and flush.
- Each cycle it picks the two oldest ready entries and drives them to ALU0 and ALU1, honouring per-ALU backpressure.
- Replaces the stateless priority select between the RS ready mask and the two ALU muxes.

Parameters:
- RS_DEPTH, Cfg.RS_DEPTH (16): number of RS entries.
- ALLOC_W, 4: dispatch lanes per cycle; lane 0 is oldest in program order.
- IDX_W, $clog2(RS_DEPTH): width of an entry index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; clears all scheduler state.
- alloc_valid  in  ALLOC_W  lane k writes an entry this cycle.
- alloc_idx  in  ALLOC_W x IDX_W  RS slot written by lane k.
- ready_mask  in  RS_DEPTH  both operands of the entry are ready.
- alu0_ready  in  1  ALU0 accepts an op this cycle.
- alu1_ready  in  1  ALU1 accepts an op this cycle.
- alu0_valid  out  1  ALU0 issue this cycle.
- alu0_rs_idx  out  IDX_W  slot issued to ALU0.
- alu1_valid  out  1  ALU1 issue this cycle.
- alu1_rs_idx  out  IDX_W  slot issued to ALU1.
- issue_grant_mask  out  RS_DEPTH  one-hot OR of the issued slots; the RS clears busy on these bits.
- entry_valid  out  RS_DEPTH  slots tracked by the scheduler.
- occupancy  out  IDX_W+1  popcount of entry_valid.

Behaviour:
- Reset (rst=1 at a clk edge): valid=0, age matrix=0. Combinationally this gives alu*_valid=0, alu*_rs_idx=0, issue_grant_mask=0, entry_valid=0, occupancy=0.
- Age semantics: age[i][j]=1 means entry i is older than entry j. The relation is only defined where both i and j are valid.
- Eligibility: elig[i] = valid[i] & ready_mask[i]. ready_mask bits of invalid slots are ignored.
- Pick oldest: first = the eligible i with no eligible j where age[j][i]=1. second = the same rule over elig with first removed.
- Grant latency: zero cycles. Selection is combinational from registered state plus ready_mask and the ALU ready inputs.
- ALU steering:
  - Both ALUs ready: first -> ALU0, second -> ALU1.
  - Only ALU1 ready: first -> ALU1.
  - Only ALU0 ready: first -> ALU0.
  - Neither ready: no grant.
  - An unused ALU has valid=0 and idx=0.
- Grant effect: valid[granted] clears at the next edge. The granted row and column of the age matrix become don't-care.
- Allocation of slot s on lane k, applied at the edge:
  - valid[s]=1.
  - For every j valid before this edge and not granted this cycle: age[j][s]=1, age[s][j]=0.
  - For each same-cycle lane m<k: age[slot_m][s]=1, age[s][slot_m]=0.
  - For each same-cycle lane m>k: the inverse.
  - age[s][s]=0.
- Same-cycle allocate and grant:
  - Grants are computed from pre-edge state, so a newly allocated entry cannot issue in its allocation cycle.
  - Allocation into a slot granted this cycle cannot occur, because the RS still reports it busy. The bench asserts this never happens.
- Protocol errors (bench asserts): allocation into a slot already valid; duplicate alloc_idx among valid lanes.
- Flush: valid=0 and age matrix=0 at the edge. Allocations in the same cycle are dropped. Grants in the flush cycle are still driven combinationally, and downstream kills them.
- Priority at the edge: rst > flush > (grant clear, allocate).
- Occupancy: next = current + allocations - grants. It never exceeds RS_DEPTH; the allocator guarantees no overfill.
- Starvation: none, because the oldest ready entry always wins the first available ALU.

Decomposition:
- sched_pkg holds:
  - the RS_IDX_W localparam;
  - the typedef rs_idx_t;
  - the typedef age_row_t (logic [RS_DEPTH-1:0]).
- One sub-module, age_oldest_pick (combinational):
  - inputs: elig vector and age matrix;
  - outputs: one-hot oldest, index, and found flag;
  - instantiated twice; the second instance receives elig with first masked out.
- The matrix update, valid vector and occupancy counter stay in rs_age_scheduler.

Test Plan:
1. Reset then idle:
   - Stimulus: rst=1 for 2 cycles, then all inputs 0.
   - Expect: alu0_valid=alu1_valid=0, issue_grant_mask=0, occupancy=0.
2. In-order dispatch, reverse readiness:
   - Stimulus: allocate slots 5,2,9 on lanes 0,1,2 in one cycle. Next cycle ready_mask selects slots 9 and 2.
   - Expect: ALU0=2 and ALU1=9 (2 is older). Slot 5 is never granted while not ready. occupancy 3 -> 1.
3. Age across cycles:
   - Stimulus: allocate slot 7 at cycle 1 and slot 3 at cycle 2. At cycle 3 both are ready, with only alu1_ready=1.
   - Expect: alu1_rs_idx=7, alu0_valid=0. At cycle 4: alu0 or alu1 issues slot 3, per readiness.
4. Backpressure:
   - Stimulus: 4 ready entries, alu0_ready=alu1_ready=0 for 3 cycles.
   - Expect: no grants and entry_valid unchanged. After release, the two oldest issue in the first cycle and the remaining two in the next.
5. Flush mid-stream:
   - Stimulus: 6 valid entries; flush=1 together with alloc of slot 11.
   - Expect: next cycle entry_valid=0, occupancy=0, slot 11 not tracked.
6. Slot reuse after grant:
   - Stimulus: grant slot 4, reallocate slot 4 the following cycle while slot 8 (older) is waiting, then make both ready.
   - Expect: ALU0=8, ALU1=4.
